// File: rtl/key_conditioner_if.sv
// Key pins in, and the conditioned key level, press strobe and release strobe out.
// The board wrapper holds the master side; key_conditioner uses the slave side.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] keys_i;
  logic [N_KEYS-1:0] keys_o;
  logic [N_KEYS-1:0] press_o;
  logic [N_KEYS-1:0] release_o;

  modport master (output keys_i, input keys_o, press_o, release_o);
  modport slave  (input keys_i, output keys_o, press_o, release_o);
endinterface

// File: rtl/key_conditioner.sv
// Each key is synchronised, then debounced on its own. The outputs are a clean level
// (1 = pressed) plus a one-cycle press strobe and a one-cycle release strobe.
module key_conditioner #(
  parameter int CLK_MHZ     = 50,
  parameter int DEBOUNCE_US = 10000,
  parameter int N_KEYS      = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  key_conditioner_if.slave         kif
);

  localparam int DEBOUNCE_CYCLES = CLK_MHZ * DEBOUNCE_US;
  localparam int CW              = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } key_state_t;

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] rel;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          raw_pressed;
    logic          synced;
    logic          done;

    // Invert before the synchroniser, so both flops reset to 0, which means released.
    assign raw_pressed = (ACTIVE_LOW != 0) ? ~kif.keys_i[i] : kif.keys_i[i];
    assign synced      = sync_q[1];
    assign done        = (cnt_q == LAST_COUNT);

    // NOTE: state registers use non-blocking assignments. Every register then samples
    // values from before the edge, whatever order the processes run in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync_q  <= 2'b00;
        state_q <= RELEASED;
        cnt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw_pressed};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // NOTE: every output of this block gets a default before the case statement.
    // A path that misses an assignment would otherwise infer a latch.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (synced) begin
            state_d = PRESS_PENDING;
            cnt_d   = ONE;
          end
        end
        PRESS_PENDING: begin
          if (!synced) begin
            state_d = RELEASED;
          end else if (done) begin
            state_d = PRESSED;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        PRESSED: begin
          if (!synced) begin
            state_d = RELEASE_PENDING;
            cnt_d   = ONE;
          end
        end
        RELEASE_PENDING: begin
          if (synced) begin
            state_d = PRESSED;
          end else if (done) begin
            state_d = RELEASED;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = RELEASED;
      endcase
    end

    // The level is decoded from the state register alone, so keys_i has no combinational path to it.
    assign level[i] = (state_q == PRESSED) || (state_q == RELEASE_PENDING);
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
  end

  assign kif.keys_o    = level;
  assign kif.press_o   = press;
  assign kif.release_o = rel;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner. A history-based model of the debounce rule checks
// every cycle, and hand-computed literal checks at the key points pin the model itself.
module tb_key_conditioner;

  localparam int CLK_MHZ     = 1;
  localparam int DEBOUNCE_US = 4;
  localparam int N_KEYS      = 2;
  localparam int ACTIVE_LOW  = 1;
  localparam int DC          = CLK_MHZ * DEBOUNCE_US;
  localparam int HIST        = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  key_conditioner_if #(.N_KEYS(N_KEYS)) kif ();

  key_conditioner #(
    .CLK_MHZ    (CLK_MHZ),
    .DEBOUNCE_US(DEBOUNCE_US),
    .N_KEYS     (N_KEYS),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .kif    (kif)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [N_KEYS-1:0] act,
                       input logic [N_KEYS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // The model keeps the pressed-sense sample taken at every edge since reset. A key
  // flips once the last DC synchronised samples all disagree with its current level
  // and all of them came after the previous flip.
  bit                model_raw [N_KEYS][HIST];
  int                ecount = 0;
  int                last_flip [N_KEYS] = '{-1000, -1000};
  logic [N_KEYS-1:0] m_level = '0;
  logic [N_KEYS-1:0] m_press = '0;
  logic [N_KEYS-1:0] m_rel   = '0;

  function automatic bit synced_at(int k, int e);
    if (e < 2) return 1'b0;
    return model_raw[k][e-2];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecount  = 0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int k = 0; k < N_KEYS; k++) last_flip[k] = -1000;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        bit all_differ;
        model_raw[k][ecount] = (ACTIVE_LOW != 0) ? ~kif.keys_i[k] : kif.keys_i[k];
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (ecount - last_flip[k] >= DC) begin
          all_differ = 1'b1;
          for (int j = 0; j < DC; j++)
            if (synced_at(k, ecount - j) == m_level[k]) all_differ = 1'b0;
          if (all_differ) begin
            m_level[k]   = ~m_level[k];
            m_press[k]   = m_level[k];
            m_rel[k]     = ~m_level[k];
            last_flip[k] = ecount;
          end
        end
      end
      if (ecount < HIST - 1) ecount++;
    end
  end

  int press_count [N_KEYS] = '{0, 0};

  always @(negedge clk) begin
    check("keys_o model", kif.keys_o, m_level);
    check("press_o model", kif.press_o, m_press);
    check("release_o model", kif.release_o, m_rel);
    for (int k = 0; k < N_KEYS; k++)
      if (kif.press_o[k] === 1'b1) press_count[k]++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pc0;
    kif.keys_i = 2'b11;
    #1 rst_n = 1'b0;

    // Reset with both keys released: every output must stay 0.
    tick(3);
    check("reset keys_o", kif.keys_o, 2'b00);
    check("reset press_o", kif.press_o, 2'b00);
    check("reset release_o", kif.release_o, 2'b00);
    rst_n = 1'b1;
    tick(20);
    check("idle keys_o", kif.keys_o, 2'b00);

    // Clean press of key 0 appears 6 ticks after the drive, which is edge N+5.
    kif.keys_i = 2'b10;
    tick(5);
    check("press N+4 keys_o", kif.keys_o, 2'b00);
    tick(1);
    check("press N+5 keys_o", kif.keys_o, 2'b01);
    check("press N+5 press_o", kif.press_o, 2'b01);
    tick(1);
    check("press N+6 press_o", kif.press_o, 2'b00);

    // Clean release of key 0.
    kif.keys_i = 2'b11;
    tick(5);
    check("release N+4 keys_o", kif.keys_o, 2'b01);
    tick(1);
    check("release N+5 keys_o", kif.keys_o, 2'b00);
    check("release N+5 release_o", kif.release_o, 2'b01);
    tick(1);
    check("release N+6 release_o", kif.release_o, 2'b00);
    tick(3);

    // Bounce: 3 low, 1 high, then held low. The flip lands on edge 9 after the first drive.
    pc0 = press_count[0];
    kif.keys_i = 2'b10;
    tick(3);
    kif.keys_i = 2'b11;
    tick(1);
    kif.keys_i = 2'b10;
    tick(5);
    check("bounce edge8 keys_o", kif.keys_o, 2'b00);
    tick(1);
    check("bounce edge9 keys_o", kif.keys_o, 2'b01);
    tick(10);
    check("bounce pulse count", 2'(press_count[0] - pc0), 2'd1);

    kif.keys_i = 2'b11;
    tick(8);

    // Press both keys on the same edge.
    kif.keys_i = 2'b00;
    tick(6);
    check("simul press_o", kif.press_o, 2'b11);
    check("simul keys_o", kif.keys_o, 2'b11);
    tick(1);

    // Release key 1, then key 0 one cycle later.
    kif.keys_i = 2'b10;
    tick(1);
    kif.keys_i = 2'b11;
    tick(5);
    check("stagger release_o key1", kif.release_o, 2'b10);
    check("stagger keys_o key1", kif.keys_o, 2'b01);
    tick(1);
    check("stagger release_o key0", kif.release_o, 2'b01);
    check("stagger keys_o key0", kif.keys_o, 2'b00);
    tick(3);

    // Reset mid-count: key 0 is already pressed and key 1 has counted 2 cycles.
    kif.keys_i = 2'b10;
    tick(7);
    check("pre-reset keys_o", kif.keys_o, 2'b01);
    kif.keys_i = 2'b00;
    tick(4);
    #2 rst_n = 1'b0;
    #1 check("async reset keys_o", kif.keys_o, 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("post-reset edge5 press_o", kif.press_o, 2'b00);
    tick(1);
    check("post-reset edge6 press_o", kif.press_o, 2'b11);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
